// File: rtl/mul_iter_stage.sv
// Iterative shift-and-add multiplier stage: one request in flight, OPERAND_SIZE
// busy cycles, then the low product bits are held in DONE until writeback accepts.
module mul_iter_stage #(
  parameter int OPERAND_SIZE = 32,
  parameter int TAG_SIZE     = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    MI_valid,
  input  logic [OPERAND_SIZE-1:0] MI_operand1,
  input  logic [OPERAND_SIZE-1:0] MI_operand2,
  input  logic [TAG_SIZE-1:0]     MI_dest,
  output logic                    MI_stall,
  input  logic                    MI_stall_in,
  output logic [OPERAND_SIZE-1:0] MI_result,
  output logic [TAG_SIZE-1:0]     MI_result_dest,
  output logic                    MI_result_valid
);

  localparam int CNT_W = (OPERAND_SIZE > 1) ? $clog2(OPERAND_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPERAND_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [OPERAND_SIZE-1:0] mcand_r;
  logic [OPERAND_SIZE-1:0] mplier_r;
  logic [OPERAND_SIZE-1:0] acc_r;
  logic [OPERAND_SIZE-1:0] acc_sum_s;
  logic [TAG_SIZE-1:0]     dest_r;
  logic [CNT_W-1:0]        count_r;
  logic                    last_s;

  // Partial-product add for the current multiplier bit; carry-out is dropped.
  always_comb begin
    acc_sum_s = acc_r;
    last_s    = (count_r == CNT_LAST);
    if (mplier_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
  end

  // Next-state logic; no early exit on zero operands so latency is fixed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (MI_valid) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (MI_stall_in) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand/accumulator datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand_r         <= '0;
      mplier_r        <= '0;
      acc_r           <= '0;
      dest_r          <= '0;
      count_r         <= '0;
      MI_result       <= '0;
      MI_result_dest  <= '0;
      MI_result_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (MI_valid) begin
            mcand_r  <= MI_operand1;
            mplier_r <= MI_operand2;
            dest_r   <= MI_dest;
            acc_r    <= '0;
            count_r  <= '0;
          end
        end
        BUSY: begin
          acc_r    <= acc_sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CNT_W'(1);
          if (last_s) begin
            MI_result       <= acc_sum_s;
            MI_result_dest  <= dest_r;
            MI_result_valid <= 1'b1;
          end
        end
        DONE: begin
          if (!MI_stall_in) begin
            MI_result_valid <= 1'b0;
          end
        end
        default: begin
          MI_result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign MI_stall = (state_r != IDLE);

endmodule

// File: tb/tb_mul_iter_stage.sv
// Directed self-checking bench for mul_iter_stage (default 32-bit operands, 5-bit tag).
module tb_mul_iter_stage;

  logic        clk;
  logic        reset_n;
  logic        MI_valid;
  logic [31:0] MI_operand1;
  logic [31:0] MI_operand2;
  logic [4:0]  MI_dest;
  logic        MI_stall;
  logic        MI_stall_in;
  logic [31:0] MI_result;
  logic [4:0]  MI_result_dest;
  logic        MI_result_valid;

  int checks_cnt;
  int fail_cnt;
  int busy_cycles;

  mul_iter_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .MI_valid        (MI_valid),
    .MI_operand1     (MI_operand1),
    .MI_operand2     (MI_operand2),
    .MI_dest         (MI_dest),
    .MI_stall        (MI_stall),
    .MI_stall_in     (MI_stall_in),
    .MI_result       (MI_result),
    .MI_result_dest  (MI_result_dest),
    .MI_result_valid (MI_result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; request is accepted at the following posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    MI_valid    = 1'b1;
    MI_operand1 = a;
    MI_operand2 = b;
    MI_dest     = d;
    @(negedge clk);
    MI_valid    = 1'b0;
  endtask

  // Counts BUSY cycles (stall high, no result) from the current negedge, bounded.
  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (MI_stall && !MI_result_valid && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] exp_res);
    issue(a, b, d);
    wait_busy(busy_cycles);
    check_val({tag, "_busy_len"}, busy_cycles, 32'd32);
    check_val({tag, "_valid"}, {31'd0, MI_result_valid}, 32'd1);
    check_val({tag, "_stall_done"}, {31'd0, MI_stall}, 32'd1);
    check_val({tag, "_result"}, MI_result, exp_res);
    check_val({tag, "_dest"}, {27'd0, MI_result_dest}, {27'd0, d});
    @(negedge clk);
    check_val({tag, "_valid_after"}, {31'd0, MI_result_valid}, 32'd0);
    check_val({tag, "_stall_after"}, {31'd0, MI_stall}, 32'd0);
  endtask

  initial begin
    checks_cnt  = 0;
    fail_cnt    = 0;
    reset_n     = 1'b0;
    MI_valid    = 1'b0;
    MI_operand1 = 32'd0;
    MI_operand2 = 32'd0;
    MI_dest     = 5'd0;
    MI_stall_in = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_stall", {31'd0, MI_stall}, 32'd0);
    check_val("rst_valid", {31'd0, MI_result_valid}, 32'd0);
    check_val("rst_result", MI_result, 32'd0);
    check_val("rst_dest", {27'd0, MI_result_dest}, 32'd0);
    reset_n = 1'b1;

    run_mul("m3x5", 32'd3, 32'd5, 5'd7, 32'd15);
    run_mul("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001);
    run_mul("m80x2", 32'h8000_0000, 32'd2, 5'd2, 32'h0000_0000);
    run_mul("mzero", 32'd0, 32'h1234_5678, 5'd4, 32'd0);
    run_mul("mneg", 32'hFFFF_FFFF, 32'd3, 5'd31, 32'hFFFF_FFFD);

    // Downstream backpressure holds DONE for 10 cycles.
    MI_stall_in = 1'b1;
    issue(32'd11, 32'd13, 5'd3);
    wait_busy(busy_cycles);
    check_val("bp_busy_len", busy_cycles, 32'd32);
    for (int i = 0; i < 10; i++) begin
      check_val("bp_valid", {31'd0, MI_result_valid}, 32'd1);
      check_val("bp_stall", {31'd0, MI_stall}, 32'd1);
      check_val("bp_result", MI_result, 32'd143);
      if (i == 9) begin
        MI_stall_in = 1'b0;
      end else begin
        MI_stall_in = 1'b1;
      end
      @(negedge clk);
    end
    check_val("bp_valid_rel", {31'd0, MI_result_valid}, 32'd0);
    check_val("bp_stall_rel", {31'd0, MI_stall}, 32'd0);
    check_val("bp_result_hold", MI_result, 32'd143);

    // MI_valid held high through BUSY must not disturb the in-flight 6x7.
    MI_valid    = 1'b1;
    MI_operand1 = 32'd6;
    MI_operand2 = 32'd7;
    MI_dest     = 5'd9;
    @(negedge clk);
    MI_operand1 = 32'd9;
    MI_operand2 = 32'd9;
    MI_dest     = 5'd10;
    wait_busy(busy_cycles);
    check_val("ign_busy_len", busy_cycles, 32'd32);
    check_val("ign_result", MI_result, 32'd42);
    check_val("ign_dest", {27'd0, MI_result_dest}, 32'd9);
    @(negedge clk);
    check_val("ign_idle_stall", {31'd0, MI_stall}, 32'd0);
    @(negedge clk);
    MI_valid = 1'b0;
    wait_busy(busy_cycles);
    check_val("ign2_busy_len", busy_cycles, 32'd32);
    check_val("ign2_result", MI_result, 32'd81);
    check_val("ign2_dest", {27'd0, MI_result_dest}, 32'd10);
    @(negedge clk);

    // Reset in BUSY cycle 10 discards the operation.
    issue(32'd100, 32'd3, 5'd5);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("mrst_stall", {31'd0, MI_stall}, 32'd0);
    check_val("mrst_valid", {31'd0, MI_result_valid}, 32'd0);
    check_val("mrst_result", MI_result, 32'd0);
    reset_n = 1'b1;
    run_mul("m4x4", 32'd4, 32'd4, 5'd6, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mul_iter_stage.md
MUL_ITER_STAGE -- requirements
Module: mul_iter_stage

Interface
REQ-001 Parameter OPERAND_SIZE, default 32: operand and result width in bits.
REQ-002 Parameter TAG_SIZE, default 5: destination-register tag width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 MI_valid  input  1  upstream presents a multiply request this cycle.
REQ-006 MI_operand1  input  OPERAND_SIZE  multiplicand.
REQ-007 MI_operand2  input  OPERAND_SIZE  multiplier.
REQ-008 MI_dest  input  TAG_SIZE  destination tag carried with the request.
REQ-009 MI_stall  output  1  tells upstream to hold; this is the source of the pipeline's stall_in chain.
REQ-010 MI_stall_in  input  1  downstream (writeback) cannot accept a result this cycle.
REQ-011 MI_result  output  OPERAND_SIZE  low OPERAND_SIZE bits of the product, registered.
REQ-012 MI_result_dest  output  TAG_SIZE  tag of the completed request, registered.
REQ-013 MI_result_valid  output  1  MI_result and MI_result_dest are valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 IDLE: MI_stall=0; on MI_valid=1, latch operands and tag, clear the accumulator, set count=0, go to BUSY; otherwise stay in IDLE.
REQ-016 BUSY: each cycle, add the multiplicand to the accumulator if multiplier bit0=1, shift the multiplicand left 1, shift the multiplier right 1, count+1.
REQ-017 BUSY SHALL last exactly OPERAND_SIZE cycles with no early termination, including for zero operands; the cycle with count=OPERAND_SIZE-1 loads MI_result and MI_result_dest and goes to DONE.
REQ-018 Arithmetic SHALL be modulo 2^OPERAND_SIZE with the carry-out discarded, so results equal the low bits of both the signed and the unsigned product.
REQ-019 DONE: MI_result_valid=1; MI_result and MI_result_dest held stable; if MI_stall_in=1 remain in DONE, else go to IDLE next edge.
REQ-020 MI_stall SHALL be combinational from state: 1 in BUSY and DONE, 0 in IDLE.
REQ-021 MI_valid in BUSY or DONE SHALL be ignored; the in-flight operation is unaffected and the upstream stage is responsible for holding the request.
REQ-022 Latency: with the request accepted at edge E and MI_stall_in=0, MI_result_valid=1 during cycle E+OPERAND_SIZE+1 only, and IDLE resumes at E+OPERAND_SIZE+2.
REQ-023 Throughput SHALL be one result per OPERAND_SIZE+2 cycles when unstalled; DONE does not accept a new request directly.
REQ-024 MI_result_valid SHALL be 0 in IDLE and BUSY; MI_result keeps its last value outside DONE.

Reset
REQ-025 reset_n=0 at a rising edge SHALL force IDLE, MI_result=0, MI_result_dest=0, MI_result_valid=0, accumulator=0 and count=0; consequently MI_stall=0.
REQ-026 Reset during BUSY or DONE SHALL discard the in-flight operation without producing a result.
REQ-027 Reset SHALL take priority over MI_valid and MI_stall_in on the same edge.

Verification
REQ-028 Reset, then MI_valid=1 with operand1=3, operand2=5, dest=7 for one cycle -> MI_stall=1 for 33 cycles, MI_result_valid=1 for exactly one cycle with MI_result=15 and MI_result_dest=7, then MI_stall=0.
REQ-029 0xFFFFFFFF x 0xFFFFFFFF -> MI_result=0x00000001; 0x80000000 x 2 -> 0x00000000.
REQ-030 0 x 0x12345678 -> MI_result=0 at the same latency as REQ-028 (no early completion).
REQ-031 Hold MI_stall_in=1 for 10 cycles after DONE entry -> MI_result_valid, MI_result and MI_stall all stable for 10 cycles; one cycle after release, MI_result_valid=0 and MI_stall=0.
REQ-032 Issue a 6x7 request, then drive MI_valid=1 with 9x9 throughout BUSY -> result is 42; the 9x9 request is accepted only after IDLE is re-entered and yields 81.
REQ-033 reset_n=0 in BUSY cycle 10 -> next edge: MI_stall=0, MI_result_valid=0, MI_result=0; a following 4x4 request yields 16 at the normal latency.
